// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential shift-and-add multiplier.
package mult_pkg;

   localparam int OP_W   = 8;
   localparam int PROD_W = 16;
   localparam int ITER   = 8;
   localparam int CNT_W  = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Bundle of internal registers, exported for checkers that bind to the multiplier.
   typedef struct packed {
      state_t           state;
      logic [CNT_W-1:0] cnt;
      logic [OP_W-1:0]  m;
   } mult_dbg_t;

endpackage

// File: rtl/adder_8bit.sv
// 8-bit ripple-carry adder: sum/carry = A + B + C, built from a chain of full adders.
module adder_8bit
   import mult_pkg::*;
(
   input  logic [OP_W-1:0] A,
   input  logic [OP_W-1:0] B,
   input  logic            C,
   output logic [OP_W-1:0] sum,
   output logic            carry
);

   logic [OP_W:0] c_chain;

   assign c_chain[0] = C;

   for (genvar i = 0; i < OP_W; i++) begin : g_fa
      assign sum[i]       = A[i] ^ B[i] ^ c_chain[i];
      assign c_chain[i+1] = (A[i] & B[i]) | (c_chain[i] & (A[i] ^ B[i]));
   end

   assign carry = c_chain[OP_W];

endmodule

// File: rtl/seq_multiplier_8bit.sv
// Sequential 8x8 unsigned multiplier: one shift-and-add iteration per clock through
// the shared ripple adder, 16-bit product {ACC,Q} after eight iterations.
module seq_multiplier_8bit
   import mult_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [OP_W-1:0]     multiplicand,
   input  logic [OP_W-1:0]     multiplier,
   output logic                busy,
   output logic                done,
   output logic [PROD_W-1:0]   product
);

   state_t           state_q, state_d;
   logic [OP_W-1:0]  m_q, m_d;
   logic [OP_W-1:0]  acc_q, acc_d;
   logic [OP_W-1:0]  q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   logic [OP_W-1:0]  addend;
   logic [OP_W-1:0]  add_sum;
   logic             add_carry;
   mult_dbg_t        dbg;

   assign addend = q_q[0] ? m_q : '0;

   adder_8bit u_adder (
      .A     (acc_q),
      .B     (addend),
      .C     (1'b0),
      .sum   (add_sum),
      .carry (add_carry)
   );

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               m_d     = multiplicand;
               q_d     = multiplier;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            // The carry-out becomes the new MSB, so no partial-sum bit is ever lost.
            {acc_d, q_d} = {add_carry, add_sum, q_q[OP_W-1:1]};
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ITER - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign dbg     = '{state: state_q, cnt: cnt_q, m: m_q};
   assign busy    = (dbg.state == RUN);
   assign done    = done_q;
   assign product = {acc_q, q_q};

endmodule

// File: tb/tb_seq_multiplier_8bit.sv
// Self-checking bench for seq_multiplier_8bit: directed vector table, multi-cycle
// corner sequences, and a randomized sweep against an arithmetic reference.
module tb_seq_multiplier_8bit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int tests_run;
   int tests_failed;

   logic [15:0] exp_q[$];

   typedef struct {
      logic [7:0]  m;
      logic [7:0]  q;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[10];

   seq_multiplier_8bit dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
   endtask

   // ---------------- driver ----------------
   // One multiply from IDLE; k counts negedges after the accepting edge E0.
   // With noisy set, start and operands toggle randomly while the block is busy.
   task automatic run_mult(input logic [7:0] m, input logic [7:0] q,
                           input logic [15:0] exp, input bit noisy);
      int          done_at;
      int          pulses;
      int          busy_n;
      logic [15:0] got;
      logic [15:0] expv;
      done_at = -1;
      pulses  = 0;
      busy_n  = 0;
      got     = '0;
      exp_q.push_back(exp);
      @(negedge clk);
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 12; k++) begin
         if (busy) busy_n++;
         if (done) begin
            pulses++;
            if (done_at < 0) begin
               done_at = k;
               got     = product;
            end
         end
         start = (noisy && k <= 7) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noisy) begin
            multiplicand = 8'($urandom);
            multiplier   = 8'($urandom);
         end
         @(negedge clk);
      end
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check("done_latency", done_at, 8);
      check("done_pulses", pulses, 1);
      check("busy_cycles", busy_n, 8);
      check("product", int'(got), int'(expv));
      check("product_hold", int'(product), int'(expv));
   endtask

   initial begin
      int dn;
      int done_k[$];
      logic [15:0] done_p[$];
      logic [7:0] rm;
      logic [7:0] rq;

      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;

      vecs[0] = '{8'h0D, 8'h0B, 16'h008F};
      vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
      vecs[2] = '{8'h00, 8'hFF, 16'h0000};
      vecs[3] = '{8'hFF, 8'h00, 16'h0000};
      vecs[4] = '{8'h01, 8'h01, 16'h0001};
      vecs[5] = '{8'h80, 8'h80, 16'h4000};
      vecs[6] = '{8'hFF, 8'h01, 16'h00FF};
      vecs[7] = '{8'h01, 8'hFF, 16'h00FF};
      vecs[8] = '{8'hAA, 8'h55, 16'h3872};
      vecs[9] = '{8'h12, 8'h34, 16'h03A8};

      // Reset state
      do_reset();
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_product", int'(product), 0);

      // Directed table
      foreach (vecs[i]) run_mult(vecs[i].m, vecs[i].q, vecs[i].exp, 1'b0);
      run_mult(8'h0D, 8'h0B, 16'h008F, 1'b1);

      // Start held high, operands changed mid-run; second multiply accepted on the done cycle
      @(negedge clk);
      multiplicand = 8'h12;
      multiplier   = 8'h34;
      start        = 1'b1;
      @(negedge clk);
      multiplicand = 8'h01;
      multiplier   = 8'h01;
      for (int k = 0; k < 22; k++) begin
         if (done) begin
            done_k.push_back(k);
            done_p.push_back(product);
         end
         if (k >= 9) start = 1'b0;
         @(negedge clk);
      end
      check("b2b_done_count", done_k.size(), 2);
      if (done_k.size() >= 2) begin
         check("b2b_first_at", done_k[0], 8);
         check("b2b_first_prod", int'(done_p[0]), 16'h03A8);
         check("b2b_second_at", done_k[1], 17);
         check("b2b_second_prod", int'(done_p[1]), 16'h0001);
      end

      // Reset after the 4th iteration of 0xFF*0xFF
      @(negedge clk);
      multiplicand = 8'hFF;
      multiplier   = 8'hFF;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_product", int'(product), 0);
      dn = 0;
      for (int k = 0; k < 12; k++) begin
         if (done || busy) dn++;
         @(negedge clk);
      end
      check("midrst_no_done", dn, 0);
      run_mult(8'h12, 8'h34, 16'h03A8, 1'b0);

      // Random sweep against the arithmetic reference
      for (int i = 0; i < 1000; i++) begin
         rm = 8'($urandom);
         rq = 8'($urandom);
         run_mult(rm, rq, 16'(rm) * 16'(rq), 1'b1);
      end
      for (int i = 0; i < 256; i++) begin
         rm = 8'(i);
         run_mult(rm, 8'h01, 16'(rm) * 16'd1, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
